y86_seq_ctrl: RTL and testbench
===============================

Name: y86_seq_ctrl

Overview:
- Parametrised multi-cycle sequencer for the Y86-64 sequential core; it replaces the free-running stage chain.
- Steps one instruction through FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK and PC_UPDATE.
- Owns the PC, condition-code and status registers, plus the retired-instruction counter.
- Stalls on a data-memory handshake and halts on HLT, ADR and INS conditions.

Parameters:
XLEN, 64, datapath/PC width in bits
RESET_PC, 0, PC value loaded on reset
MEM_TIMEOUT, 16, max cycles waiting for mem_ack before ADR fault; 0 disables the timeout
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
run  in  1  permit start of next instruction
icode  in  4  fetched instruction code
ifun  in  4  fetched function code
instr_valid  in  1  fetch decoded a legal icode/ifun
imem_err  in  1  fetch address invalid
valC  in  XLEN  constant word
valP  in  XLEN  fall-through PC
valM  in  XLEN  memory read data
zf_in, sf_in, of_in  in  1 each  ALU flags for current valE
mem_ack  in  1  data memory completed access
dmem_err  in  1  data memory fault, qualified by mem_ack
pc  out  XLEN  current PC
stage_en  out  6  one-hot stage enable; bit0 FETCH ... bit5 PC_UPDATE
mem_req  out  1  data-memory request
cc  out  3  {ZF,SF,OF}
cnd  out  1  condition result for JXX/CMOVXX
stat  out  3  1=AOK 2=HLT 3=ADR 4=INS
halted  out  1  core stopped
icount  out  CNT_W  retired instructions

Behaviour:
- Reset (rst_n=0 at clk edge):
  - pc=RESET_PC, state=FETCH, cc=3'b100, cnd=0, stat=AOK, halted=0, icount=0, mem_req=0.
  - stage_en=0 until the first cycle with run=1.
  - Reset overrides any state, including mid-MEMORY wait and HALTED.
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PC_UPDATE, HALTED.
  - stage_en reflects the registered state and is 0 in HALTED.
- FETCH:
  - Advances only if run=1; otherwise holds with stage_en=0.
  - Priority: imem_err -> stat=ADR; else !instr_valid -> stat=INS; else icode==0 -> stat=HLT.
  - Any of these -> HALTED, pc unchanged, icount unchanged.
  - Otherwise -> DECODE.
- DECODE: one cycle -> EXECUTE.
- EXECUTE: one cycle -> MEMORY.
  - If icode==6 (OPQ): cc <= {zf_in,sf_in,of_in} at end of cycle.
  - cnd is evaluated on pre-update cc and registered; it is valid from MEMORY onward.
  - cnd by ifun: 0 always 1; 1 (SF^OF)|ZF; 2 SF^OF; 3 ZF; 4 !ZF; 5 !(SF^OF); 6 !(SF^OF)&!ZF; >6 gives 0.
- MEMORY:
  - Memory icodes are 4, 5, 8, 9, A and B.
  - For these, mem_req=1 from state entry until the cycle mem_ack=1, inclusive.
  - mem_ack and dmem_err -> stat=ADR, HALTED.
  - mem_ack alone -> WRITEBACK.
  - Wait counter counts cycles without ack; reaching MEM_TIMEOUT -> stat=ADR, HALTED, mem_req drops next cycle.
  - Non-memory icodes: mem_req=0, one cycle, -> WRITEBACK.
  - mem_ack outside a request is ignored.
- WRITEBACK: one cycle -> PC_UPDATE.
- PC_UPDATE: one cycle, then icount+1 (wraps modulo 2^CNT_W) -> FETCH.
  - pc <= valC if icode==8.
  - pc <= valC if icode==7 and cnd.
  - pc <= valM if icode==9.
  - else pc <= valP.
- Latency: 6 cycles per non-memory instruction; 5+N for memory instructions whose ack arrives in MEMORY cycle N.
- HALTED: sticky; all outputs hold; run is ignored; only reset exits.
- stat changes only on entry to HALTED.

Decomposition:
- Shared package y86_pkg:
  - icode constants (HALT, NOP, CMOVXX, IRMOVQ, RMMOVQ, MRMOVQ, OPQ, JXX, CALL, RET, PUSHQ, POPQ).
  - stat codes.
  - stage-state enum.
  - ifun condition encodings.
- One sub-module, y86_cond: combinational cc/ifun -> cnd evaluator, reusable by the future pipelined core.

Test Plan:
- Reset with RESET_PC=0x100, run=1, icode=1, valP=0x101 -> stage_en walks 1,2,4,8,16,32; pc=0x101 after 6 cycles; icount=1; cc=100.
- OPQ with zf_in=0, sf_in=1, of_in=0, then JXX ifun=2 with valC=0x40 -> cc=010, cnd=1, pc=0x40.
- MRMOVQ with mem_ack on the 3rd MEMORY cycle -> mem_req high exactly 3 cycles; total 8 cycles; icount increments.
- PUSHQ with no ack, MEM_TIMEOUT=4 -> mem_req high 4 cycles, then stat=3, halted=1; pc and icount unchanged.
- icode=0 -> stat=2, halted=1, pc held. Later instr_valid=0 after reset -> stat=4. Reset asserted mid-MEMORY -> all reset values the next cycle.
- run=0 in FETCH for 5 cycles -> stage_en=0, pc held; run=1 resumes. icount at all-ones wraps to 0.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, status codes, sequencer states
// and condition encodings used by the sequential and future pipelined cores.
package y86_pkg;

    localparam int unsigned ICODE_W = 4;
    localparam int unsigned STAT_W  = 3;
    localparam int unsigned STAGE_N = 6;

    localparam logic [ICODE_W-1:0] I_HALT   = 4'h0;
    localparam logic [ICODE_W-1:0] I_NOP    = 4'h1;
    localparam logic [ICODE_W-1:0] I_CMOVXX = 4'h2;
    localparam logic [ICODE_W-1:0] I_IRMOVQ = 4'h3;
    localparam logic [ICODE_W-1:0] I_RMMOVQ = 4'h4;
    localparam logic [ICODE_W-1:0] I_MRMOVQ = 4'h5;
    localparam logic [ICODE_W-1:0] I_OPQ    = 4'h6;
    localparam logic [ICODE_W-1:0] I_JXX    = 4'h7;
    localparam logic [ICODE_W-1:0] I_CALL   = 4'h8;
    localparam logic [ICODE_W-1:0] I_RET    = 4'h9;
    localparam logic [ICODE_W-1:0] I_PUSHQ  = 4'hA;
    localparam logic [ICODE_W-1:0] I_POPQ   = 4'hB;

    localparam logic [STAT_W-1:0] STAT_AOK = 3'd1;
    localparam logic [STAT_W-1:0] STAT_HLT = 3'd2;
    localparam logic [STAT_W-1:0] STAT_ADR = 3'd3;
    localparam logic [STAT_W-1:0] STAT_INS = 3'd4;

    localparam logic [ICODE_W-1:0] C_ALWAYS = 4'h0;
    localparam logic [ICODE_W-1:0] C_LE     = 4'h1;
    localparam logic [ICODE_W-1:0] C_L      = 4'h2;
    localparam logic [ICODE_W-1:0] C_E      = 4'h3;
    localparam logic [ICODE_W-1:0] C_NE     = 4'h4;
    localparam logic [ICODE_W-1:0] C_GE     = 4'h5;
    localparam logic [ICODE_W-1:0] C_G      = 4'h6;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_PC_UPDATE = 3'd5,
        S_HALTED    = 3'd6
    } stage_e;

    // Instructions that touch data memory and therefore handshake in MEMORY.
    function automatic logic is_mem_icode(input logic [ICODE_W-1:0] ic);
        return (ic == I_RMMOVQ) || (ic == I_MRMOVQ) || (ic == I_CALL) ||
               (ic == I_RET)    || (ic == I_PUSHQ)  || (ic == I_POPQ);
    endfunction

endpackage

// File: rtl/y86_cond.sv
// Combinational condition evaluator: {ZF,SF,OF} and ifun -> branch/cmov condition.
module y86_cond
    import y86_pkg::*;
(
    input  logic [2:0] cc,
    input  logic [3:0] ifun,
    output logic       cnd_c
);

    logic zf;
    logic sf;
    logic of;

    assign zf = cc[2];
    assign sf = cc[1];
    assign of = cc[0];

    always_comb begin
        cnd_c = 1'b0;
        case (ifun)
            C_ALWAYS: cnd_c = 1'b1;
            C_LE:     cnd_c = (sf ^ of) | zf;
            C_L:      cnd_c = sf ^ of;
            C_E:      cnd_c = zf;
            C_NE:     cnd_c = ~zf;
            C_GE:     cnd_c = ~(sf ^ of);
            C_G:      cnd_c = ~(sf ^ of) & ~zf;
            default:  cnd_c = 1'b0;
        endcase
    end

endmodule

// File: rtl/y86_seq_ctrl.sv
// Multi-cycle Y86-64 sequencer: steps one instruction through the six stages,
// owns PC, CC, status and retired count, and handles the data-memory handshake.
module y86_seq_ctrl
    import y86_pkg::*;
#(
    parameter int unsigned      XLEN        = 64,
    parameter logic [XLEN-1:0]  RESET_PC    = '0,
    parameter int unsigned      MEM_TIMEOUT = 16,
    parameter int unsigned      CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [3:0]       icode,
    input  logic [3:0]       ifun,
    input  logic             instr_valid,
    input  logic             imem_err,
    input  logic [XLEN-1:0]  valC,
    input  logic [XLEN-1:0]  valP,
    input  logic [XLEN-1:0]  valM,
    input  logic             zf_in,
    input  logic             sf_in,
    input  logic             of_in,
    input  logic             mem_ack,
    input  logic             dmem_err,
    output logic [XLEN-1:0]  pc,
    output logic [5:0]       stage_en,
    output logic             mem_req,
    output logic [2:0]       cc,
    output logic             cnd,
    output logic [2:0]       stat,
    output logic             halted,
    output logic [CNT_W-1:0] icount
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    stage_e            state;
    logic [3:0]        ir_icode;
    logic [3:0]        ir_ifun;
    logic [WAIT_W-1:0] wait_cnt;
    logic              cnd_c;

    y86_cond u_cond (
        .cc    (cc),
        .ifun  (ir_ifun),
        .cnd_c (cnd_c)
    );

    // FETCH is only enabled in a cycle where the core is permitted to run.
    always_comb begin
        stage_en = '0;
        case (state)
            S_FETCH:     stage_en[0] = run;
            S_DECODE:    stage_en[1] = 1'b1;
            S_EXECUTE:   stage_en[2] = 1'b1;
            S_MEMORY:    stage_en[3] = 1'b1;
            S_WRITEBACK: stage_en[4] = 1'b1;
            S_PC_UPDATE: stage_en[5] = 1'b1;
            default:     stage_en    = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            pc       <= RESET_PC;
            cc       <= 3'b100;
            cnd      <= 1'b0;
            stat     <= STAT_AOK;
            halted   <= 1'b0;
            icount   <= '0;
            mem_req  <= 1'b0;
            wait_cnt <= '0;
            ir_icode <= I_NOP;
            ir_ifun  <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (run) begin
                        if (imem_err) begin
                            stat   <= STAT_ADR;
                            halted <= 1'b1;
                            state  <= S_HALTED;
                        end else if (!instr_valid) begin
                            stat   <= STAT_INS;
                            halted <= 1'b1;
                            state  <= S_HALTED;
                        end else if (icode == I_HALT) begin
                            stat   <= STAT_HLT;
                            halted <= 1'b1;
                            state  <= S_HALTED;
                        end else begin
                            ir_icode <= icode;
                            ir_ifun  <= ifun;
                            state    <= S_DECODE;
                        end
                    end
                end
                S_DECODE: state <= S_EXECUTE;
                // cnd samples cc before this cycle's OPQ flag update.
                S_EXECUTE: begin
                    if (ir_icode == I_OPQ) begin
                        cc <= {zf_in, sf_in, of_in};
                    end
                    cnd      <= cnd_c;
                    mem_req  <= is_mem_icode(ir_icode);
                    wait_cnt <= '0;
                    state    <= S_MEMORY;
                end
                S_MEMORY: begin
                    if (mem_req) begin
                        if (mem_ack) begin
                            mem_req <= 1'b0;
                            if (dmem_err) begin
                                stat   <= STAT_ADR;
                                halted <= 1'b1;
                                state  <= S_HALTED;
                            end else begin
                                state <= S_WRITEBACK;
                            end
                        end else if ((MEM_TIMEOUT != 0) &&
                                     (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1))) begin
                            mem_req <= 1'b0;
                            stat    <= STAT_ADR;
                            halted  <= 1'b1;
                            state   <= S_HALTED;
                        end else begin
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                    end else begin
                        state <= S_WRITEBACK;
                    end
                end
                S_WRITEBACK: state <= S_PC_UPDATE;
                S_PC_UPDATE: begin
                    if (ir_icode == I_CALL) begin
                        pc <= valC;
                    end else if ((ir_icode == I_JXX) && cnd) begin
                        pc <= valC;
                    end else if (ir_icode == I_RET) begin
                        pc <= valM;
                    end else begin
                        pc <= valP;
                    end
                    icount <= icount + CNT_W'(1);
                    state  <= S_FETCH;
                end
                S_HALTED: state <= S_HALTED;
                default:  state <= S_HALTED;
            endcase
        end
    end

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// Directed self-checking bench for y86_seq_ctrl (RESET_PC=0x100, MEM_TIMEOUT=4, CNT_W=4).
module tb_y86_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic        instr_valid;
    logic        imem_err;
    logic [63:0] valC;
    logic [63:0] valP;
    logic [63:0] valM;
    logic        zf_in;
    logic        sf_in;
    logic        of_in;
    logic        mem_ack;
    logic        dmem_err;
    logic [63:0] pc;
    logic [5:0]  stage_en;
    logic        mem_req;
    logic [2:0]  cc;
    logic        cnd;
    logic [2:0]  stat;
    logic        halted;
    logic [3:0]  icount;

    int checks;
    int failures;

    y86_seq_ctrl #(
        .XLEN        (64),
        .RESET_PC    (64'h100),
        .MEM_TIMEOUT (4),
        .CNT_W       (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .icode       (icode),
        .ifun        (ifun),
        .instr_valid (instr_valid),
        .imem_err    (imem_err),
        .valC        (valC),
        .valP        (valP),
        .valM        (valM),
        .zf_in       (zf_in),
        .sf_in       (sf_in),
        .of_in       (of_in),
        .mem_ack     (mem_ack),
        .dmem_err    (dmem_err),
        .pc          (pc),
        .stage_en    (stage_en),
        .mem_req     (mem_req),
        .cc          (cc),
        .cnd         (cnd),
        .stat        (stat),
        .halted      (halted),
        .icount      (icount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_instr(input logic [3:0] ic, input logic [3:0] fn,
                             input logic [63:0] c, input logic [63:0] p,
                             input logic [63:0] m);
        icode = ic; ifun = fn; valC = c; valP = p; valM = m;
        instr_valid = 1'b1; imem_err = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; run = 1'b0; mem_ack = 1'b0; dmem_err = 1'b0;
        imem_err = 1'b0; instr_valid = 1'b1;
        cyc(1);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pc !== 64'h100) begin failures++; $display("FAIL reset_pc got=%h exp=%h", pc, 64'h100); end
        checks++; if (stage_en !== 6'd0) begin failures++; $display("FAIL reset_stage got=%b exp=0", stage_en); end
        checks++; if (cc !== 3'b100) begin failures++; $display("FAIL reset_cc got=%b exp=100", cc); end
        checks++; if (stat !== 3'd1 || halted !== 1'b0) begin failures++; $display("FAIL reset_stat got=%0d/%b exp=1/0", stat, halted); end
        checks++; if (icount !== 4'd0 || mem_req !== 1'b0 || cnd !== 1'b0) begin failures++; $display("FAIL reset_misc got=%0d/%b/%b exp=0/0/0", icount, mem_req, cnd); end
    endtask

    task automatic test_nop_walk();
        logic [5:0] exp_se;
        set_instr(4'h1, 4'h0, 64'h0, 64'h101, 64'h0);
        run = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            exp_se = 6'b1 << i;
            checks++; if (stage_en !== exp_se) begin failures++; $display("FAIL walk_stage%0d got=%b exp=%b", i, stage_en, exp_se); end
            cyc(1);
        end
        checks++; if (pc !== 64'h101) begin failures++; $display("FAIL walk_pc got=%h exp=101", pc); end
        checks++; if (icount !== 4'd1 || cc !== 3'b100) begin failures++; $display("FAIL walk_cnt_cc got=%0d/%b exp=1/100", icount, cc); end
    endtask

    task automatic test_opq_jxx();
        set_instr(4'h6, 4'h1, 64'h0, 64'h10b, 64'h0);
        zf_in = 1'b0; sf_in = 1'b1; of_in = 1'b0;
        cyc(6);
        checks++; if (cc !== 3'b010) begin failures++; $display("FAIL opq_cc got=%b exp=010", cc); end
        set_instr(4'h7, 4'h2, 64'h40, 64'h200, 64'h0);
        zf_in = 1'b1; sf_in = 1'b0; of_in = 1'b0;
        cyc(3);
        checks++; if (cnd !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL jxx_cnd got=%b/%b exp=1/0", cnd, mem_req); end
        cyc(3);
        checks++; if (pc !== 64'h40 || cc !== 3'b010) begin failures++; $display("FAIL jxx_pc got=%h/%b exp=40/010", pc, cc); end
        checks++; if (icount !== 4'd3) begin failures++; $display("FAIL jxx_icount got=%0d exp=3", icount); end
    endtask

    task automatic test_mem_ack();
        int req_cnt;
        req_cnt = 0;
        set_instr(4'h5, 4'h0, 64'h0, 64'h4a, 64'h0);
        cyc(3);
        for (int n = 1; n <= 3; n++) begin
            mem_ack = (n == 3);
            #1;
            if (mem_req === 1'b1) req_cnt++;
            cyc(1);
            mem_ack = 1'b0;
        end
        checks++; if (req_cnt !== 3 || mem_req !== 1'b0) begin failures++; $display("FAIL mrmov_req got=%0d/%b exp=3/0", req_cnt, mem_req); end
        checks++; if (stage_en !== 6'b010000) begin failures++; $display("FAIL mrmov_wb got=%b exp=010000", stage_en); end
        cyc(2);
        checks++; if (pc !== 64'h4a || icount !== 4'd4 || stage_en !== 6'd1) begin failures++; $display("FAIL mrmov_done got=%h/%0d/%b exp=4a/4/000001", pc, icount, stage_en); end
    endtask

    task automatic test_call_ret();
        set_instr(4'h8, 4'h0, 64'h80, 64'h55, 64'h0);
        cyc(4);
        mem_ack = 1'b1;
        cyc(1);
        mem_ack = 1'b0;
        cyc(2);
        checks++; if (pc !== 64'h80 || icount !== 4'd5) begin failures++; $display("FAIL call_pc got=%h/%0d exp=80/5", pc, icount); end
        set_instr(4'h9, 4'h0, 64'h0, 64'h99, 64'h55);
        cyc(3);
        mem_ack = 1'b1;
        cyc(1);
        mem_ack = 1'b0;
        cyc(2);
        checks++; if (pc !== 64'h55 || icount !== 4'd6) begin failures++; $display("FAIL ret_pc got=%h/%0d exp=55/6", pc, icount); end
        set_instr(4'h7, 4'h3, 64'h300, 64'h60, 64'h0);
        cyc(3);
        checks++; if (cnd !== 1'b0) begin failures++; $display("FAIL jne_cnd got=%b exp=0", cnd); end
        cyc(3);
        checks++; if (pc !== 64'h60) begin failures++; $display("FAIL jxx_nt_pc got=%h exp=60", pc); end
    endtask

    task automatic test_stray_ack();
        set_instr(4'h1, 4'h0, 64'h0, 64'h69, 64'h0);
        cyc(3);
        mem_ack = 1'b1; dmem_err = 1'b1;
        cyc(1);
        mem_ack = 1'b0; dmem_err = 1'b0;
        cyc(2);
        checks++; if (stat !== 3'd1 || halted !== 1'b0 || pc !== 64'h69 || icount !== 4'd8) begin
            failures++; $display("FAIL stray_ack got=%0d/%b/%h/%0d exp=1/0/69/8", stat, halted, pc, icount);
        end
    endtask

    task automatic test_timeout();
        int req_cnt;
        req_cnt = 0;
        set_instr(4'hA, 4'h0, 64'h0, 64'h777, 64'h0);
        cyc(3);
        for (int n = 0; n < 6; n++) begin
            #1;
            if (mem_req === 1'b1) req_cnt++;
            cyc(1);
        end
        checks++; if (req_cnt !== 4) begin failures++; $display("FAIL timeout_req got=%0d exp=4", req_cnt); end
        checks++; if (stat !== 3'd3 || halted !== 1'b1 || stage_en !== 6'd0) begin failures++; $display("FAIL timeout_halt got=%0d/%b/%b exp=3/1/0", stat, halted, stage_en); end
        checks++; if (pc !== 64'h69 || icount !== 4'd8) begin failures++; $display("FAIL timeout_hold got=%h/%0d exp=69/8", pc, icount); end
    endtask

    task automatic test_halt_codes();
        do_reset();
        set_instr(4'h0, 4'h0, 64'h0, 64'h101, 64'h0);
        run = 1'b1;
        cyc(3);
        checks++; if (stat !== 3'd2 || halted !== 1'b1 || pc !== 64'h100) begin failures++; $display("FAIL hlt got=%0d/%b/%h exp=2/1/100", stat, halted, pc); end
        do_reset();
        set_instr(4'h1, 4'h0, 64'h0, 64'h101, 64'h0);
        instr_valid = 1'b0;
        run = 1'b1;
        cyc(1);
        checks++; if (stat !== 3'd4 || halted !== 1'b1 || icount !== 4'd0) begin failures++; $display("FAIL ins got=%0d/%b/%0d exp=4/1/0", stat, halted, icount); end
        do_reset();
        set_instr(4'h1, 4'h0, 64'h0, 64'h101, 64'h0);
        instr_valid = 1'b0; imem_err = 1'b1;
        run = 1'b1;
        cyc(1);
        checks++; if (stat !== 3'd3 || halted !== 1'b1) begin failures++; $display("FAIL adr_prio got=%0d/%b exp=3/1", stat, halted); end
        do_reset();
        set_instr(4'hB, 4'h0, 64'h0, 64'h10a, 64'h0);
        run = 1'b1;
        cyc(4);
        mem_ack = 1'b1; dmem_err = 1'b1;
        cyc(1);
        mem_ack = 1'b0; dmem_err = 1'b0;
        checks++; if (stat !== 3'd3 || halted !== 1'b1 || mem_req !== 1'b0 || pc !== 64'h100) begin
            failures++; $display("FAIL dmem_err got=%0d/%b/%b/%h exp=3/1/0/100", stat, halted, mem_req, pc);
        end
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        set_instr(4'h6, 4'h0, 64'h0, 64'h102, 64'h0);
        zf_in = 1'b1; sf_in = 1'b1; of_in = 1'b1;
        run = 1'b1;
        cyc(6);
        set_instr(4'h4, 4'h0, 64'h0, 64'h10c, 64'h0);
        cyc(4);
        checks++; if (mem_req !== 1'b1 || stage_en !== 6'b001000) begin failures++; $display("FAIL pre_rst_mem got=%b/%b exp=1/001000", mem_req, stage_en); end
        rst_n = 1'b0; run = 1'b0;
        cyc(1);
        rst_n = 1'b1;
        checks++; if (pc !== 64'h100 || mem_req !== 1'b0 || icount !== 4'd0 || cc !== 3'b100 || stage_en !== 6'd0) begin
            failures++; $display("FAIL mid_mem_rst got=%h/%b/%0d/%b/%b exp=100/0/0/100/0", pc, mem_req, icount, cc, stage_en);
        end
    endtask

    task automatic test_stall_wrap();
        set_instr(4'h1, 4'h0, 64'h0, 64'h101, 64'h0);
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (stage_en !== 6'd0 || pc !== 64'h100) begin failures++; $display("FAIL stall%0d got=%b/%h exp=0/100", i, stage_en, pc); end
            cyc(1);
        end
        run = 1'b1;
        cyc(6);
        checks++; if (pc !== 64'h101 || icount !== 4'd1) begin failures++; $display("FAIL resume got=%h/%0d exp=101/1", pc, icount); end
        cyc(6 * 14);
        checks++; if (icount !== 4'd15) begin failures++; $display("FAIL cnt_max got=%0d exp=15", icount); end
        cyc(6);
        checks++; if (icount !== 4'd0) begin failures++; $display("FAIL cnt_wrap got=%0d exp=0", icount); end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst_n = 1'b0; run = 1'b0;
        icode = 4'h1; ifun = 4'h0; instr_valid = 1'b1; imem_err = 1'b0;
        valC = '0; valP = '0; valM = '0;
        zf_in = 1'b0; sf_in = 1'b0; of_in = 1'b0;
        mem_ack = 1'b0; dmem_err = 1'b0;
        cyc(2);
        test_reset();
        test_nop_walk();
        test_opq_jxx();
        test_mem_ack();
        test_call_ret();
        test_stray_ack();
        test_timeout();
        test_halt_codes();
        test_reset_mid_mem();
        test_stall_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
